// File: rtl/icache_pkg.sv
// Shared definitions for the direct-mapped instruction cache: default geometry,
// derived address-field widths and the controller state encoding.
package icache_pkg;

  localparam int unsigned ICACHE_ADDR_SIZE  = 10;
  localparam int unsigned ICACHE_LINE_WORDS = 4;
  localparam int unsigned ICACHE_LINES      = 16;

  localparam int unsigned ICACHE_WORD_W  = $clog2(ICACHE_LINE_WORDS);
  localparam int unsigned ICACHE_INDEX_W = $clog2(ICACHE_LINES);
  localparam int unsigned ICACHE_TAG_W   = ICACHE_ADDR_SIZE - 2 - ICACHE_WORD_W - ICACHE_INDEX_W;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOOKUP,
    ST_FILL_REQ,
    ST_FILL_WAIT,
    ST_RESPOND
  } state_e;

endpackage

// File: rtl/icache_data_array.sv
// Line storage for the instruction cache: LINES x LINE_WORDS x 32 registers,
// one synchronous write port and one asynchronous read port.
module icache_data_array
  import icache_pkg::*;
#(
  parameter int unsigned LINE_WORDS = ICACHE_LINE_WORDS,
  parameter int unsigned LINES      = ICACHE_LINES
) (
  input  logic                          clk_i,
  input  logic                          we_i,
  input  logic [$clog2(LINES)-1:0]      wr_line_i,
  input  logic [$clog2(LINE_WORDS)-1:0] wr_word_i,
  input  logic [31:0]                   wr_data_i,
  input  logic [$clog2(LINES)-1:0]      rd_line_i,
  input  logic [$clog2(LINE_WORDS)-1:0] rd_word_i,
  output logic [31:0]                   rd_data_o
);

  localparam int unsigned WORD_W  = $clog2(LINE_WORDS);
  localparam int unsigned INDEX_W = $clog2(LINES);
  localparam int unsigned DEPTH   = LINES * LINE_WORDS;

  logic [31:0] mem_q [DEPTH];

  // Contents need no reset; the valid bits in the top level guard every read.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[{wr_line_i, wr_word_i}] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[{rd_line_i, rd_word_i}];

endmodule

// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache between the memory controller ROM port
// and the ROM. Optional hit/miss counters are enabled with ICACHE_STATS_EN.
module instruction_cache
  import icache_pkg::*;
#(
  parameter int unsigned ADDR_SIZE  = ICACHE_ADDR_SIZE,
  parameter int unsigned LINE_WORDS = ICACHE_LINE_WORDS,
  parameter int unsigned LINES      = ICACHE_LINES
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 c_enable,
  input  logic [ADDR_SIZE-1:0] c_addr,
  output logic [31:0]          c_data,
  output logic                 c_busy,
  output logic                 m_enable,
  output logic [ADDR_SIZE-1:0] m_addr,
  input  logic [31:0]          m_data,
  input  logic                 m_busy,
  input  logic                 flush
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]          hit_count,
  output logic [31:0]          miss_count
`endif
);

  localparam int unsigned WORD_W  = $clog2(LINE_WORDS);
  localparam int unsigned INDEX_W = $clog2(LINES);
  localparam int unsigned TAG_W   = ADDR_SIZE - 2 - WORD_W - INDEX_W;
  localparam int unsigned WADDR_W = ADDR_SIZE - 2;

  state_e               state_q, state_d;
  logic [WADDR_W-1:0]   addr_q, addr_d;
  logic [WORD_W-1:0]    cnt_q, cnt_d;
  logic [31:0]          c_data_q, c_data_d;
  logic                 c_busy_q, c_busy_d;
  logic                 m_enable_q, m_enable_d;
  logic [ADDR_SIZE-1:0] m_addr_q, m_addr_d;
  logic                 seen_busy_q, seen_busy_d;
  logic                 en_prev_q;
  logic                 flush_pending_q, flush_pending_d;
  logic [LINES-1:0]     valid_q, valid_d;
  logic [TAG_W-1:0]     tag_q [LINES];

  logic [WORD_W-1:0]    req_word_c;
  logic [INDEX_W-1:0]   req_index_c;
  logic [TAG_W-1:0]     req_tag_c;
  logic                 lookup_hit_c;
  logic                 fill_we_c;
  logic                 tag_we_c;
  logic                 hit_c;
  logic                 miss_c;
  logic [31:0]          rd_data_c;
  logic                 unused_addr_bits_c;

  assign req_word_c   = addr_q[WORD_W-1:0];
  assign req_index_c  = addr_q[WORD_W+INDEX_W-1:WORD_W];
  assign req_tag_c    = addr_q[WADDR_W-1:WORD_W+INDEX_W];
  assign lookup_hit_c = valid_q[req_index_c] && (tag_q[req_index_c] == req_tag_c);

  // Byte-offset bits are never looked at.
  assign unused_addr_bits_c = ^c_addr[1:0];

  icache_data_array #(
    .LINE_WORDS (LINE_WORDS),
    .LINES      (LINES)
  ) u_data (
    .clk_i     (clock),
    .we_i      (fill_we_c),
    .wr_line_i (req_index_c),
    .wr_word_i (cnt_q),
    .wr_data_i (m_data),
    .rd_line_i (req_index_c),
    .rd_word_i (req_word_c),
    .rd_data_o (rd_data_c)
  );

  // Tags need no reset; a line is only trusted once its valid bit is set.
  always_ff @(posedge clock) begin
    if (tag_we_c) begin
      tag_q[req_index_c] <= req_tag_c;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      addr_q          <= '0;
      cnt_q           <= '0;
      c_data_q        <= '0;
      c_busy_q        <= 1'b0;
      m_enable_q      <= 1'b0;
      m_addr_q        <= '0;
      seen_busy_q     <= 1'b0;
      en_prev_q       <= 1'b0;
      flush_pending_q <= 1'b0;
      valid_q         <= '0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      cnt_q           <= cnt_d;
      c_data_q        <= c_data_d;
      c_busy_q        <= c_busy_d;
      m_enable_q      <= m_enable_d;
      m_addr_q        <= m_addr_d;
      seen_busy_q     <= seen_busy_d;
      en_prev_q       <= c_enable;
      flush_pending_q <= flush_pending_d;
      valid_q         <= valid_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    addr_d          = addr_q;
    cnt_d           = cnt_q;
    c_data_d        = c_data_q;
    c_busy_d        = c_busy_q;
    m_enable_d      = m_enable_q;
    m_addr_d        = m_addr_q;
    seen_busy_d     = seen_busy_q;
    flush_pending_d = flush_pending_q | flush;
    valid_d         = valid_q;
    fill_we_c       = 1'b0;
    tag_we_c        = 1'b0;
    hit_c           = 1'b0;
    miss_c          = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        // A pending flush takes effect here, before any request in this cycle is looked up.
        if (flush_pending_q) begin
          valid_d         = '0;
          flush_pending_d = flush;
        end
        if (c_enable && !en_prev_q) begin
          addr_d   = c_addr[ADDR_SIZE-1:2];
          c_busy_d = 1'b1;
          state_d  = ST_LOOKUP;
        end
      end
      ST_LOOKUP: begin
        if (lookup_hit_c) begin
          hit_c    = 1'b1;
          c_busy_d = 1'b0;
          c_data_d = rd_data_c;
          state_d  = ST_RESPOND;
        end else begin
          miss_c  = 1'b1;
          cnt_d   = '0;
          state_d = ST_FILL_REQ;
        end
      end
      ST_FILL_REQ: begin
        m_enable_d  = 1'b1;
        m_addr_d    = {req_tag_c, req_index_c, cnt_q, 2'b00};
        seen_busy_d = 1'b0;
        state_d     = ST_FILL_WAIT;
      end
      ST_FILL_WAIT: begin
        if (!seen_busy_q) begin
          seen_busy_d = m_busy;
        end else if (!m_busy) begin
          fill_we_c  = 1'b1;
          m_enable_d = 1'b0;
          if (cnt_q == WORD_W'(LINE_WORDS - 1)) begin
            valid_d[req_index_c] = 1'b1;
            tag_we_c             = 1'b1;
            state_d              = ST_RESPOND;
          end else begin
            cnt_d   = cnt_q + WORD_W'(1);
            state_d = ST_FILL_REQ;
          end
        end
      end
      ST_RESPOND: begin
        c_busy_d = 1'b0;
        c_data_d = rd_data_c;
        state_d  = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign c_data   = c_data_q;
  assign c_busy   = c_busy_q;
  assign m_enable = m_enable_q;
  assign m_addr   = m_addr_q;

`ifdef ICACHE_STATS_EN
  logic [31:0] hit_q, hit_d;
  logic [31:0] miss_q, miss_d;

  // Saturating lookup-outcome counters, untouched by flush.
  always_comb begin
    hit_d  = hit_q;
    miss_d = miss_q;
    if (hit_c && (hit_q != 32'hFFFF_FFFF)) begin
      hit_d = hit_q + 32'd1;
    end
    if (miss_c && (miss_q != 32'hFFFF_FFFF)) begin
      miss_d = miss_q + 32'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else begin
      hit_q  <= hit_d;
      miss_q <= miss_d;
    end
  end

  assign hit_count  = hit_q;
  assign miss_count = miss_q;
`else
  logic unused_stats_c;
  assign unused_stats_c = hit_c ^ miss_c;
`endif

endmodule

// File: tb/tb_instruction_cache.sv
// Directed bench for instruction_cache: a 12-cycle busy ROM model behind the cache
// and a simple fetch driver on the memory-controller side.
module tb_instruction_cache;

  logic        clock;
  logic        reset;
  logic        c_enable;
  logic [9:0]  c_addr;
  logic [31:0] c_data;
  logic        c_busy;
  logic        m_enable;
  logic [9:0]  m_addr;
  logic [31:0] m_data;
  logic        m_busy;
  logic        flush;
`ifdef ICACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  int total = 0;
  int bad   = 0;

  instruction_cache dut (
    .clock    (clock),
    .reset    (reset),
    .c_enable (c_enable),
    .c_addr   (c_addr),
    .c_data   (c_data),
    .c_busy   (c_busy),
    .m_enable (m_enable),
    .m_addr   (m_addr),
    .m_data   (m_data),
    .m_busy   (m_busy),
    .flush    (flush)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] rom_word(input logic [9:0] a);
    return 32'hC0DE_0000 | {22'd0, a};
  endfunction

  // ROM model: a rising m_enable starts a read; busy for 12 cycles, then data.
  logic       rom_prev;
  int         rom_cnt;
  logic [9:0] rom_addr;
  int         rom_reads = 0;
  logic [9:0] rom_log [$];

  always @(posedge clock) begin
    if (reset) begin
      m_busy   <= 1'b0;
      m_data   <= 32'd0;
      rom_cnt  <= 0;
      rom_prev <= 1'b0;
    end else begin
      rom_prev <= m_enable;
      if (rom_cnt != 0) begin
        rom_cnt <= rom_cnt - 1;
        if (rom_cnt == 1) begin
          m_busy <= 1'b0;
          m_data <= rom_word(rom_addr);
        end
      end else if (m_enable && !rom_prev) begin
        m_busy    <= 1'b1;
        rom_cnt   <= 12;
        rom_addr  <= m_addr;
        rom_reads <= rom_reads + 1;
        rom_log.push_back(m_addr);
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at a negedge with c_enable low and seen low by the DUT.
  task automatic fetch(input logic [9:0] a, input int hold, output int bcyc, output int held_busy);
    int guard;
    c_addr   = a;
    c_enable = 1'b1;
    @(posedge clock); #1;
    bcyc  = 0;
    guard = 0;
    while (c_busy === 1'b1 && guard < 300) begin
      bcyc++;
      guard++;
      @(posedge clock); #1;
    end
    if (guard >= 300) begin
      total++;
      bad++;
      $error("FAIL timeout addr=%h: c_busy observed %b expected 0", a, c_busy);
    end
    held_busy = 0;
    repeat (hold) begin
      @(posedge clock); #1;
      if (c_busy !== 1'b0) held_busy++;
    end
    @(negedge clock);
    c_enable = 1'b0;
    @(negedge clock);
  endtask

  initial begin
    int r0;
    int bc;
    int hb;

    reset    = 1'b1;
    c_enable = 1'b0;
    c_addr   = '0;
    flush    = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("reset_c_data",   c_data,          32'd0);
    check("reset_c_busy",   32'(c_busy),     32'd0);
    check("reset_m_enable", 32'(m_enable),   32'd0);
    check("reset_m_addr",   32'(m_addr),     32'd0);

    // 1: cold miss fills the whole line
    r0 = rom_reads;
    fetch(10'h010, 0, bc, hb);
    check("t1_reads",   32'(rom_reads - r0), 32'd4);
    check("t1_rd0",     32'(rom_log[r0]),     32'h010);
    check("t1_rd1",     32'(rom_log[r0+1]),   32'h014);
    check("t1_rd2",     32'(rom_log[r0+2]),   32'h018);
    check("t1_rd3",     32'(rom_log[r0+3]),   32'h01C);
    check("t1_data",    c_data,               32'hC0DE_0010);
    check("t1_latency", 32'(bc),              32'd62);
`ifdef ICACHE_STATS_EN
    check("t1_miss_count", miss_count, 32'd1);
`endif

    // 2: hit in the same line
    r0 = rom_reads;
    fetch(10'h018, 0, bc, hb);
    check("t2_busy_cycles", 32'(bc),              32'd1);
    check("t2_reads",       32'(rom_reads - r0),  32'd0);
    check("t2_data",        c_data,               32'hC0DE_0018);
`ifdef ICACHE_STATS_EN
    check("t2_hit_count", hit_count, 32'd1);
`endif

    // 3: conflict on index 1 evicts the first line
    r0 = rom_reads;
    fetch(10'h110, 0, bc, hb);
    check("t3_reads",  32'(rom_reads - r0), 32'd4);
    check("t3_rd0",    32'(rom_log[r0]),     32'h110);
    check("t3_data",   c_data,               32'hC0DE_0110);
    r0 = rom_reads;
    fetch(10'h010, 0, bc, hb);
    check("t3_reread_reads", 32'(rom_reads - r0), 32'd4);
    check("t3_reread_data",  c_data,              32'hC0DE_0010);

    // 4: flush while a fill is waiting on the ROM
    r0 = rom_reads;
    fork
      fetch(10'h210, 0, bc, hb);
      begin
        repeat (10) @(posedge clock);
        @(negedge clock);
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
      end
    join
    check("t4_reads", 32'(rom_reads - r0), 32'd4);
    check("t4_data",  c_data,              32'hC0DE_0210);
    r0 = rom_reads;
    fetch(10'h210, 0, bc, hb);
    check("t4_repeat_reads", 32'(rom_reads - r0), 32'd4);
    check("t4_repeat_data",  c_data,              32'hC0DE_0210);

    // 5: enable held high after a hit response is not a new request
    r0 = rom_reads;
    fetch(10'h214, 20, bc, hb);
    check("t5_data",       c_data,              32'hC0DE_0214);
    check("t5_held_busy",  32'(hb),             32'd0);
    check("t5_reads",      32'(rom_reads - r0), 32'd0);

    // 6: reset during the third word of a fill
    r0 = rom_reads;
    c_addr   = 10'h300;
    c_enable = 1'b1;
    repeat (38) @(negedge clock);
    check("t6_in_word2", 32'(rom_reads - r0), 32'd3);
    reset    = 1'b1;
    c_enable = 1'b0;
    @(posedge clock); #1;
    check("t6_rst_c_data",   c_data,        32'd0);
    check("t6_rst_c_busy",   32'(c_busy),   32'd0);
    check("t6_rst_m_enable", 32'(m_enable), 32'd0);
    check("t6_rst_m_addr",   32'(m_addr),   32'd0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    r0 = rom_reads;
    fetch(10'h300, 0, bc, hb);
    check("t6_refill_reads", 32'(rom_reads - r0), 32'd4);
    check("t6_refill_rd0",   32'(rom_log[r0]),     32'h300);
    check("t6_refill_data",  c_data,               32'hC0DE_0300);
    r0 = rom_reads;
    fetch(10'h30C, 0, bc, hb);
    check("t6_hit_reads", 32'(rom_reads - r0), 32'd0);
    check("t6_hit_data",  c_data,              32'hC0DE_030C);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
